// File: rtl/bc_pkg.sv
// Shared types and constants for the four-lane FIR output serializer.
package bc_pkg;

   localparam int unsigned N      = 12;
   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = N + 1;
   localparam int unsigned WORD_W = LANE_W * LANES;
   localparam int unsigned LIDX_W = $clog2(LANES);

   typedef logic [N:0]        lane_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {IDLE, SEND} ser_state_t;

   // Extract lane k of a packed word; lane 0 sits in the low bits.
   function automatic lane_t lane_sel(input word_t w, input logic [LIDX_W-1:0] k);
      return w[k*LANE_W +: LANE_W];
   endfunction

endpackage

// File: rtl/bc_word_fifo.sv
// Packed-word FIFO; accepts a push when full only if a pop happens the same cycle.
module bc_word_fifo
   import bc_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push_req,
   input  logic              pop,
   input  logic [WORD_W-1:0] wr_word,
   output logic [WORD_W-1:0] rd_word,
   output logic [PTR_W:0]    level,
   output logic              accept_c,
   output logic              reject_c
);

   localparam int unsigned LVL_W = PTR_W + 1;

   word_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full_c;

   // Push acceptance: room available, or the head word leaves this cycle
   always_comb begin
      full_c   = (level == LVL_W'(DEPTH));
      accept_c = push_req && (!full_c || pop);
      reject_c = push_req && full_c && !pop;
   end

   always_comb begin
      rd_word = mem[rd_ptr];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (accept_c) begin
         mem[wr_ptr] <= wr_word;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({accept_c, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/bc_out_serializer.sv
// Buffers packed four-lane words and streams them lane 0..3 over valid/ready.
// Optional BC_SER_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module bc_out_serializer
   import bc_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in,
   output logic [N:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_lane,
   output logic [PTR_W:0]    level,
   output logic              drop
`ifdef BC_SER_DROP_CNT_EN
  ,output logic [15:0]       drop_count
`endif
);

   localparam int unsigned        LVL_W     = PTR_W + 1;
   localparam logic [LIDX_W-1:0]  LAST_LANE = LIDX_W'(LANES - 1);

   ser_state_t         state;
   ser_state_t         state_nxt;
   logic [LIDX_W-1:0]  lane;
   word_t              rd_word;
   logic               accept_c;
   logic               reject_c;
   logic               pop_c;

   bc_word_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_req (in_valid),
      .pop      (pop_c),
      .wr_word  (in),
      .rd_word  (rd_word),
      .level    (level),
      .accept_c (accept_c),
      .reject_c (reject_c)
   );

   // Head word retires when its last lane is accepted
   always_comb begin
      pop_c = (state == SEND) && out_ready && (lane == LAST_LANE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stay in SEND across word boundaries while another word is or becomes available
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (level != '0) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (pop_c && !(level > LVL_W'(1)) && !accept_c) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_lane  = '0;
      if (state == SEND) begin
         out_valid = 1'b1;
         out_data  = lane_sel(rd_word, lane);
         out_lane  = 2'(lane);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lane <= '0;
      end else if ((state == SEND) && out_ready) begin
         lane <= (lane == LAST_LANE) ? '0 : lane + LIDX_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop <= 1'b0;
      end else begin
         drop <= reject_c;
      end
   end

`ifdef BC_SER_DROP_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_count <= '0;
      end else if (reject_c && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end
`endif

endmodule
